bus_rr_sched: RTL and testbench

BUS_RR_SCHED -- requirements
Module: bus_rr_sched

---
 rtl/bus_rr_sched_pkg.sv | 18 +
 rtl/bus_rr_sched_if.sv | 24 ++
 rtl/bus_rr_sched_rr_arbiter.sv | 28 ++
 rtl/bus_rr_sched.sv | 119 +++++++++++
 tb/tb_bus_rr_sched.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/bus_rr_sched_pkg.sv
// Shared types and helpers for the round-robin bus scheduler.
package bus_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } sched_state_e;

  localparam logic [7:0] BCAST_DEF = 8'hFF;
  localparam int         PKT_MAX   = 64;

  // Destination ID lives in the top byte of a packet of width sz.
  function automatic logic [7:0] get_dest(input logic [PKT_MAX-1:0] pkt, input int sz);
    get_dest = 8'(pkt >> (sz - 8));
  endfunction

endpackage

// File: rtl/bus_rr_sched_if.sv
// Driver-side FIFO handshake bundle between the scheduler and its ports.
interface bus_rr_sched_if #(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16
);
  logic [drvrs-1:0]              pndng;
  logic [drvrs-1:0][pckg_sz-1:0] D_pop;
  logic [drvrs-1:0]              pop;
  logic [drvrs-1:0]              push;
  logic [drvrs-1:0][pckg_sz-1:0] D_push;
  logic                          busy;
  logic [3:0]                    grant_id;
  logic                          drop;

  modport master (
    input  pndng, D_pop,
    output pop, push, D_push, busy, grant_id, drop
  );

  modport slave (
    output pndng, D_pop,
    input  pop, push, D_push, busy, grant_id, drop
  );
endinterface

// File: rtl/bus_rr_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request above 'last', wrapping.
module rr_arbiter #(
  parameter int drvrs = 4
) (
  input  logic [drvrs-1:0] req,
  input  logic [3:0]       last,
  output logic [3:0]       gnt_id,
  output logic             valid
);
  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

  logic [IW-1:0] idx_s;
  logic          hit_s;

  // Scan upward from last+1; the first hit latches and later hits are ignored.
  always_comb begin
    gnt_id = 4'd0;
    valid  = 1'b0;
    idx_s  = '0;
    hit_s  = 1'b0;
    for (int i = 1; i <= drvrs; i++) begin
      idx_s  = IW'((int'(last) + i) % drvrs);
      hit_s  = req[idx_s] && !valid;
      gnt_id = hit_s ? 4'(idx_s) : gnt_id;
      valid  = valid | hit_s;
    end
  end
endmodule

// File: rtl/bus_rr_sched.sv
// Shared-bus scheduler: pops one packet from a round-robin granted port and
// delivers it to its destination port (or all others on broadcast).
module bus_rr_sched
  import bus_sched_pkg::*;
#(
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = BCAST_DEF
) (
  input  logic            clk,
  input  logic            reset,
  bus_rr_sched_if.master  bus
);
  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

  sched_state_e                  state_r;
  logic [3:0]                    grant_r;
  logic [3:0]                    last_r;
  logic [drvrs-1:0]              pop_r;
  logic [drvrs-1:0]              push_r;
  logic [drvrs-1:0][pckg_sz-1:0] d_push_r;
  logic [pckg_sz-1:0]            pkt_r;
  logic                          busy_r;
  logic                          drop_r;

  logic [3:0]       arb_gnt_s;
  logic             arb_valid_s;
  logic [IW-1:0]    gidx_s;
  logic [drvrs-1:0] gnt_mask_s;
  logic [7:0]       dest_s;
  logic [drvrs-1:0] push_nxt_s;
  logic             drop_nxt_s;

  rr_arbiter #(.drvrs(drvrs)) u_arb (
    .req    (bus.pndng),
    .last   (last_r),
    .gnt_id (arb_gnt_s),
    .valid  (arb_valid_s)
  );

  assign gidx_s     = grant_r[IW-1:0];
  assign gnt_mask_s = {{(drvrs-1){1'b0}}, 1'b1} << gidx_s;
  assign dest_s     = get_dest(PKT_MAX'(pkt_r), pckg_sz);

  // Routing decision for the captured packet; the source port never receives it.
  always_comb begin
    push_nxt_s = '0;
    drop_nxt_s = 1'b0;
    if (dest_s == broadcast) begin
      push_nxt_s = ~gnt_mask_s;
    end else if ((int'(dest_s) < drvrs) && (dest_s != {4'd0, grant_r})) begin
      push_nxt_s = {{(drvrs-1){1'b0}}, 1'b1} << dest_s;
    end else begin
      drop_nxt_s = 1'b1;
    end
  end

  // Three-phase transfer FSM with fully registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      grant_r  <= 4'd0;
      last_r   <= 4'(drvrs - 1);
      pop_r    <= '0;
      push_r   <= '0;
      d_push_r <= '0;
      pkt_r    <= '0;
      busy_r   <= 1'b0;
      drop_r   <= 1'b0;
    end else begin
      pop_r  <= '0;
      push_r <= '0;
      drop_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (arb_valid_s) begin
            grant_r <= arb_gnt_s;
            last_r  <= arb_gnt_s;
            state_r <= POP;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        POP: begin
          pop_r   <= gnt_mask_s;
          pkt_r   <= bus.D_pop[gidx_s];
          state_r <= PUSH;
          busy_r  <= 1'b1;
        end
        PUSH: begin
          push_r <= push_nxt_s;
          drop_r <= drop_nxt_s;
          for (int i = 0; i < drvrs; i++) begin
            if (push_nxt_s[i]) begin
              d_push_r[i] <= pkt_r;
            end else begin
              d_push_r[i] <= d_push_r[i];
            end
          end
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pop      = pop_r;
  assign bus.push     = push_r;
  assign bus.D_push   = d_push_r;
  assign bus.busy     = busy_r;
  assign bus.grant_id = grant_r;
  assign bus.drop     = drop_r;

endmodule

// File: tb/tb_bus_rr_sched.sv
// Directed bench for bus_rr_sched: vector table of single transfers plus
// reset-abort, spacing and fairness sequences.
module tb_bus_rr_sched;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_rr_sched_if #(.drvrs(4), .pckg_sz(16)) bus ();

  bus_rr_sched #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]       pndng;
    logic [3:0][15:0] dpop;
    logic [3:0]       gnt;
    logic [3:0]       push;
    logic             drop;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  vec_t        vecs[11];
  logic [15:0] exp_dp[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] pn, input logic [1:0] port,
                              input logic [15:0] data, input logic [3:0] push,
                              input logic drop);
    vec_t r;
    r.pndng = pn;
    for (int i = 0; i < 4; i++) r.dpop[i] = 16'hDEAD;
    r.dpop[port] = data;
    r.gnt  = {2'b00, port};
    r.push = push;
    r.drop = drop;
    return r;
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    bus.pndng = 4'b0000;
    bus.D_pop = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int p = 0; p < 4; p++) exp_dp[p] = 16'h0000;
  endtask

  initial begin
    logic [3:0] exp_pop;
    int         pop_cyc[8];
    logic [3:0] pop_val[8];
    int         npop;
    int         cnt0, cnt2, alt_err, bad_pat, prev;

    // grant order follows last_grant: 3 -> 0,1,3,2,3,0,1,2,3,0,1
    vecs[0]  = mk(4'b0001, 2'd0, 16'h02AB, 4'b0100, 1'b0);
    vecs[1]  = mk(4'b0010, 2'd1, 16'hFF55, 4'b1101, 1'b0);
    vecs[2]  = mk(4'b1000, 2'd3, 16'h0712, 4'b0000, 1'b1);
    vecs[3]  = mk(4'b0100, 2'd2, 16'h0234, 4'b0000, 1'b1);
    vecs[4]  = mk(4'b1111, 2'd3, 16'h0099, 4'b0001, 1'b0);
    vecs[5]  = mk(4'b1111, 2'd0, 16'h0301, 4'b1000, 1'b0);
    vecs[6]  = mk(4'b1111, 2'd1, 16'h0102, 4'b0000, 1'b1);
    vecs[7]  = mk(4'b1111, 2'd2, 16'h0155, 4'b0010, 1'b0);
    vecs[8]  = mk(4'b1010, 2'd3, 16'hFFAA, 4'b0111, 1'b0);
    vecs[9]  = mk(4'b0011, 2'd0, 16'h0400, 4'b0000, 1'b1);
    vecs[10] = mk(4'b0011, 2'd1, 16'h0000, 4'b0001, 1'b0);

    do_reset();
    chk("rst pop",  bus.pop, 4'b0000);
    chk("rst push", bus.push, 4'b0000);
    chk("rst drop", bus.drop, 1'b0);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst grant", bus.grant_id, 4'd0);
    chk("rst dpush", bus.D_push, 64'h0);

    for (int v = 0; v < 11; v++) begin
      bus.pndng = vecs[v].pndng;
      bus.D_pop = vecs[v].dpop;
      exp_pop   = 4'b0001 << vecs[v].gnt;
      tick();
      chk($sformatf("v%0d grant", v), bus.grant_id, vecs[v].gnt);
      chk($sformatf("v%0d busy1", v), bus.busy, 1'b1);
      chk($sformatf("v%0d pop0", v), bus.pop, 4'b0000);
      chk($sformatf("v%0d drop0", v), bus.drop, 1'b0);
      tick();
      chk($sformatf("v%0d pop", v), bus.pop, exp_pop);
      chk($sformatf("v%0d busy2", v), bus.busy, 1'b1);
      chk($sformatf("v%0d push0", v), bus.push, 4'b0000);
      bus.pndng = 4'b0000;
      tick();
      chk($sformatf("v%0d push", v), bus.push, vecs[v].push);
      chk($sformatf("v%0d drop", v), bus.drop, vecs[v].drop);
      chk($sformatf("v%0d busy3", v), bus.busy, 1'b0);
      chk($sformatf("v%0d pop1", v), bus.pop, 4'b0000);
      for (int p = 0; p < 4; p++) begin
        if (vecs[v].push[p]) exp_dp[p] = vecs[v].dpop[vecs[v].gnt[1:0]];
        chk($sformatf("v%0d dpush%0d", v, p), bus.D_push[p], exp_dp[p]);
      end
    end

    // Reset landing on the POP cycle aborts the transfer.
    do_reset();
    bus.pndng = 4'b0100;
    bus.D_pop = {16'h0000, 16'h0001, 16'h0000, 16'h0000};
    tick();
    chk("abort grant2", bus.grant_id, 4'd2);
    reset = 1'b1;
    tick();
    chk("abort push", bus.push, 4'b0000);
    chk("abort busy", bus.busy, 1'b0);
    chk("abort pop", bus.pop, 4'b0000);
    chk("abort grant", bus.grant_id, 4'd0);
    reset     = 1'b0;
    bus.pndng = 4'b0101;
    bus.D_pop = {16'h0000, 16'h0001, 16'h0000, 16'h0201};
    tick();
    chk("after abort grant", bus.grant_id, 4'd0);
    tick();
    chk("after abort pop", bus.pop, 4'b0001);
    bus.pndng = 4'b0000;
    tick();
    chk("after abort push", bus.push, 4'b0100);
    chk("after abort data", bus.D_push[2], 16'h0201);

    // All ports pending: order 0,1,2,3,0 with pops every third cycle.
    do_reset();
    bus.pndng = 4'b1111;
    bus.D_pop = {16'h0001, 16'h0001, 16'h0001, 16'h0001};
    npop = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (bus.pop != 4'b0000) begin
        if (npop < 8) begin
          pop_cyc[npop] = c;
          pop_val[npop] = bus.pop;
        end
        npop++;
      end
    end
    chk("spacing count", npop, 5);
    for (int k = 0; k < 5 && k < npop; k++) begin
      chk($sformatf("spacing cyc%0d", k), pop_cyc[k], 2 + 3 * k);
      chk($sformatf("spacing port%0d", k), pop_val[k], 4'b0001 << (k % 4));
    end

    // Two ports always pending: strict alternation, no starvation.
    do_reset();
    bus.pndng = 4'b0101;
    bus.D_pop = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
    npop = 0; cnt0 = 0; cnt2 = 0; alt_err = 0; bad_pat = 0; prev = -1;
    for (int c = 0; c < 320 && npop < 100; c++) begin
      tick();
      if (bus.pop == 4'b0001) begin
        if (prev == 0) alt_err++;
        prev = 0; cnt0++; npop++;
      end else if (bus.pop == 4'b0100) begin
        if (prev == 2 || prev == -1) alt_err++;
        prev = 2; cnt2++; npop++;
      end else if (bus.pop != 4'b0000) begin
        bad_pat++;
      end
    end
    chk("fair packets", npop, 100);
    chk("fair alternation", alt_err, 0);
    chk("fair pattern", bad_pat, 0);
    chk("fair port0", cnt0, 50);
    chk("fair port2", cnt2, 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
